// File: rtl/mem_monitor_pkg.sv
// mem_monitor_pkg: shared state type, status encodings and counter width
// for the mem_write_monitor store checker and its store log.
package mem_monitor_pkg;

    // Width of the store and cycle counters.
    localparam int CNT_W = 16;

    // Monitor FSM states; everything except S_RUN is terminal until reset.
    typedef enum logic [1:0] {
        S_RUN,
        S_PASS,
        S_FAIL,
        S_TIMEOUT
    } monitorState_e;

    // Encodings presented on the status output.
    localparam logic [1:0] ST_RUNNING = 2'b00;
    localparam logic [1:0] ST_PASS    = 2'b01;
    localparam logic [1:0] ST_FAIL    = 2'b10;
    localparam logic [1:0] ST_TIMEOUT = 2'b11;

endpackage

// File: rtl/store_log_buf.sv
// store_log_buf: circular log of {address, data, valid} for recent stores.
// Writes land at the write pointer, which then advances and wraps, so the
// oldest entry is overwritten. Reads are combinational and relative to the
// newest entry (rdIdx 0 = most recent store). Entries that have never been
// written since reset read back as all zeros.
module store_log_buf #(
    parameter int DEPTH = 8,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wrEn,
    input  logic [31:0]      wrAdr,
    input  logic [31:0]      wrData,
    input  logic [IDX_W-1:0] rdIdx,
    output logic [31:0]      rdAdr,
    output logic [31:0]      rdData,
    output logic             rdValid
);

    logic [31:0]      adrMem  [DEPTH];
    logic [31:0]      dataMem [DEPTH];
    logic [DEPTH-1:0] validBits;
    logic [IDX_W-1:0] wrPtr;
    logic [IDX_W-1:0] rdPtr;

    // Write pointer and valid bits are the only state that needs clearing on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr     <= '0;
            validBits <= '0;
        end else if (wrEn) begin
            validBits[wrPtr] <= 1'b1;
            wrPtr            <= wrPtr + IDX_W'(1);
        end
    end

    // Payload storage; stale contents are hidden by the valid bits so no reset is needed.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            adrMem[wrPtr]  <= wrAdr;
            dataMem[wrPtr] <= wrData;
        end
    end

    // Map the newest-relative index onto a physical slot and gate unwritten slots to zero.
    always_comb begin
        rdPtr   = wrPtr - IDX_W'(1) - rdIdx;
        rdValid = validBits[rdPtr];
        rdAdr   = rdValid ? adrMem[rdPtr]  : 32'd0;
        rdData  = rdValid ? dataMem[rdPtr] : 32'd0;
    end

endmodule

// File: rtl/mem_write_monitor.sv
// mem_write_monitor: watches the processor's data-memory write bus and
// latches a sticky verdict (running / pass / fail / timeout), counting
// stores and idle cycles while running.
// Optional feature: define MEM_WRITE_MONITOR_LOG_EN to build a LOG_DEPTH
// entry circular log of recent stores readable through log_rd_idx.
// Without it the log outputs are tied to zero and log_rd_idx is ignored.
module mem_write_monitor
    import mem_monitor_pkg::*;
#(
    parameter logic [31:0] PASS_ADR       = 32'd100,
    parameter logic [31:0] PASS_DATA      = 32'd25,
    parameter int          TIMEOUT_CYCLES = 500,
    parameter int          LOG_DEPTH      = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         MemWrite,
    input  logic [31:0]                  DataAdr,
    input  logic [31:0]                  WriteData,
    output logic [1:0]                   status,
    output logic                         done,
    output logic [CNT_W-1:0]             store_count,
    output logic [CNT_W-1:0]             cycle_count,
    input  logic [$clog2(LOG_DEPTH)-1:0] log_rd_idx,
    output logic [31:0]                  log_adr,
    output logic [31:0]                  log_data,
    output logic                         log_valid
);

    localparam int              IDX_W        = $clog2(LOG_DEPTH);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

    monitorState_e state;

    // Verdict FSM with registered status/done and the two counters; a store to
    // the pass address is checked before the timeout so it wins a same-cycle tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_RUN;
            status      <= ST_RUNNING;
            done        <= 1'b0;
            store_count <= '0;
            cycle_count <= '0;
        end else if (state == S_RUN) begin
            if (MemWrite && (store_count != CNT_MAX)) begin
                store_count <= store_count + CNT_W'(1);
            end
            if (MemWrite && (DataAdr == PASS_ADR)) begin
                done <= 1'b1;
                if (WriteData == PASS_DATA) begin
                    state  <= S_PASS;
                    status <= ST_PASS;
                end else begin
                    state  <= S_FAIL;
                    status <= ST_FAIL;
                end
            end else if (cycle_count == TIMEOUT_LAST) begin
                state  <= S_TIMEOUT;
                status <= ST_TIMEOUT;
                done   <= 1'b1;
            end else if (!MemWrite) begin
                cycle_count <= cycle_count + CNT_W'(1);
            end
        end
    end

`ifdef MEM_WRITE_MONITOR_LOG_EN
    logic logWrEn;

    // Only stores seen while running are logged, including the deciding one.
    assign logWrEn = MemWrite && (state == S_RUN) && !reset;

    store_log_buf #(
        .DEPTH (LOG_DEPTH),
        .IDX_W (IDX_W)
    ) logBuf (
        .clk     (clk),
        .reset   (reset),
        .wrEn    (logWrEn),
        .wrAdr   (DataAdr),
        .wrData  (WriteData),
        .rdIdx   (log_rd_idx),
        .rdAdr   (log_adr),
        .rdData  (log_data),
        .rdValid (log_valid)
    );
`else
    logic unusedLogIdx;

    // No log storage in this build; the read index is deliberately consumed and dropped.
    assign unusedLogIdx = ^log_rd_idx;
    assign log_adr      = 32'd0;
    assign log_data     = 32'd0;
    assign log_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_write_monitor.sv
// tb_mem_write_monitor: directed stimulus with a scoreboard queue; a negedge
// monitor pops expectations as they fall due and compares DUT outputs.
module tb_mem_write_monitor;
    import mem_monitor_pkg::*;

    localparam int K_STATUS = 0;
    localparam int K_DONE   = 1;
    localparam int K_STORES = 2;
    localparam int K_CYCLES = 3;
    localparam int K_LADR   = 4;
    localparam int K_LDATA  = 5;
    localparam int K_LVALID = 6;

    typedef struct {
        string       name;
        int          kind;
        int          due;
        logic [31:0] expVal;
    } expect_t;

    logic        clk       = 1'b0;
    logic        reset     = 1'b0;
    logic        memWrite  = 1'b0;
    logic [31:0] dataAdr   = '0;
    logic [31:0] writeData = '0;
    logic [2:0]  logRdIdx  = '0;
    logic [1:0]  status;
    logic        done;
    logic [15:0] storeCount;
    logic [15:0] cycleCount;
    logic [31:0] logAdr;
    logic [31:0] logData;
    logic        logValid;

    int      tbCycle     = 0;
    int      testsRun    = 0;
    int      testsFailed = 0;
    expect_t sbQueue[$];

    mem_write_monitor dut (
        .clk         (clk),
        .reset       (reset),
        .MemWrite    (memWrite),
        .DataAdr     (dataAdr),
        .WriteData   (writeData),
        .status      (status),
        .done        (done),
        .store_count (storeCount),
        .cycle_count (cycleCount),
        .log_rd_idx  (logRdIdx),
        .log_adr     (logAdr),
        .log_data    (logData),
        .log_valid   (logValid)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle index used to schedule scoreboard expectations.
    always @(posedge clk) tbCycle <= tbCycle + 1;

    function automatic logic [31:0] actualOf(int kind);
        case (kind)
            K_STATUS: return {30'd0, status};
            K_DONE:   return {31'd0, done};
            K_STORES: return {16'd0, storeCount};
            K_CYCLES: return {16'd0, cycleCount};
            K_LADR:   return logAdr;
            K_LDATA:  return logData;
            default:  return {31'd0, logValid};
        endcase
    endfunction

    // Expected log output: the real value when the log is built, zero otherwise.
    function automatic logic [31:0] logExp(logic [31:0] v);
`ifdef MEM_WRITE_MONITOR_LOG_EN
        return v;
`else
        return (v & 32'd0);
`endif
    endfunction

    // Scoreboard monitor: compare every expectation that falls due this cycle.
    always @(negedge clk) begin
        expect_t e;
        logic [31:0] act;
        while (sbQueue.size() > 0 && sbQueue[0].due <= tbCycle) begin
            e   = sbQueue.pop_front();
            act = actualOf(e.kind);
            testsRun++;
            if (e.due != tbCycle || act !== e.expVal) begin
                testsFailed++;
                $display("[TB] FAIL %s: got %0d expected %0d (due %0d, now %0d)",
                         e.name, act, e.expVal, e.due, tbCycle);
            end
        end
    end

    task automatic checkOutput(input string name, input int kind, input logic [31:0] val,
                               input int offset);
        expect_t e;
        e.name   = name;
        e.kind   = kind;
        e.due    = tbCycle + offset;
        e.expVal = val;
        sbQueue.push_back(e);
    endtask

    // Drive one cycle of bus activity; it is sampled on the next rising edge.
    task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [31:0] data);
        @(posedge clk);
        #1;
        memWrite  = we;
        dataAdr   = adr;
        writeData = data;
    endtask

    task automatic pulseReset(input logic we, input logic [31:0] adr, input logic [31:0] data);
        @(posedge clk);
        #1;
        reset     = 1'b1;
        memWrite  = we;
        dataAdr   = adr;
        writeData = data;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        memWrite = 1'b0;
    endtask

    task automatic resetDut(input string tag);
        pulseReset(1'b0, 32'd0, 32'd0);
        logRdIdx = 3'd0;
        checkOutput({tag, " rst status"}, K_STATUS, 32'd0, 0);
        checkOutput({tag, " rst done"},   K_DONE,   32'd0, 0);
        checkOutput({tag, " rst stores"}, K_STORES, 32'd0, 0);
        checkOutput({tag, " rst cycles"}, K_CYCLES, 32'd0, 0);
    endtask

    initial begin
        // Basic pass: (96,7) then (100,25).
        resetDut("t1");
        checkOutput("t1 rst logValid", K_LVALID, 32'd0, 0);
        checkOutput("t1 rst logAdr",   K_LADR,   32'd0, 0);
        checkOutput("t1 rst logData",  K_LDATA,  32'd0, 0);
        applyStimulus(1'b1, 32'd96, 32'd7);
        checkOutput("t1 running after 96", K_STATUS, 32'd0, 1);
        applyStimulus(1'b1, 32'd100, 32'd25);
        checkOutput("t1 status pass", K_STATUS, 32'd1, 1);
        checkOutput("t1 done",        K_DONE,   32'd1, 1);
        checkOutput("t1 stores",      K_STORES, 32'd2, 1);
        applyStimulus(1'b0, 32'd0, 32'd0);
        checkOutput("t1 log0 adr",   K_LADR,   logExp(32'd100), 0);
        checkOutput("t1 log0 data",  K_LDATA,  logExp(32'd25), 0);
        checkOutput("t1 log0 valid", K_LVALID, logExp(32'd1), 0);
        applyStimulus(1'b1, 32'd100, 32'd26);
        logRdIdx = 3'd1;
        checkOutput("t1 log1 adr",  K_LADR,  logExp(32'd96), 0);
        checkOutput("t1 log1 data", K_LDATA, logExp(32'd7), 0);
        checkOutput("t1 sticky pass",  K_STATUS, 32'd1, 1);
        checkOutput("t1 stores frozen", K_STORES, 32'd2, 1);
        applyStimulus(1'b0, 32'd0, 32'd0);
        logRdIdx = 3'd0;
        checkOutput("t1 post-verdict not logged", K_LADR, logExp(32'd100), 1);

        // Wrong data at the pass address, then a late correct store.
        resetDut("t2");
        applyStimulus(1'b1, 32'd100, 32'd26);
        checkOutput("t2 status fail", K_STATUS, 32'd2, 1);
        checkOutput("t2 done",        K_DONE,   32'd1, 1);
        checkOutput("t2 stores",      K_STORES, 32'd1, 1);
        applyStimulus(1'b1, 32'd100, 32'd25);
        checkOutput("t2 sticky fail",  K_STATUS, 32'd2, 1);
        checkOutput("t2 stores frozen", K_STORES, 32'd1, 1);
        applyStimulus(1'b0, 32'd0, 32'd0);

        // Timeout after 500 idle cycles, counter frozen at 499.
        resetDut("t3");
        for (int i = 0; i < 498; i++) applyStimulus(1'b0, 32'd0, 32'd0);
        checkOutput("t3 running at 499", K_STATUS, 32'd0, 1);
        checkOutput("t3 cycles 499",     K_CYCLES, 32'd499, 1);
        applyStimulus(1'b0, 32'd0, 32'd0);
        checkOutput("t3 status timeout", K_STATUS, 32'd3, 1);
        checkOutput("t3 done",           K_DONE,   32'd1, 1);
        checkOutput("t3 cycles held",    K_CYCLES, 32'd499, 1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'd100, 32'd25);
        checkOutput("t3 sticky timeout", K_STATUS, 32'd3, 1);
        checkOutput("t3 cycles frozen",  K_CYCLES, 32'd499, 1);
        checkOutput("t3 no stores",      K_STORES, 32'd0, 1);
        applyStimulus(1'b0, 32'd0, 32'd0);

        // Pass store on the timeout-threshold cycle wins.
        resetDut("t4");
        for (int i = 0; i < 498; i++) applyStimulus(1'b0, 32'd0, 32'd0);
        checkOutput("t4 cycles 499", K_CYCLES, 32'd499, 1);
        applyStimulus(1'b1, 32'd100, 32'd25);
        checkOutput("t4 pass beats timeout", K_STATUS, 32'd1, 1);
        checkOutput("t4 stores",             K_STORES, 32'd1, 1);
        applyStimulus(1'b0, 32'd0, 32'd0);

        // Ten stores wrap the log; then a mid-stream reset clears everything.
        resetDut("t5");
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 32'(4 * i), 32'(32'h100 + i));
        checkOutput("t5 stores 10",  K_STORES, 32'd10, 1);
        checkOutput("t5 still running", K_STATUS, 32'd0, 1);
        for (int idx = 0; idx < 8; idx++) begin
            applyStimulus(1'b0, 32'd0, 32'd0);
            logRdIdx = 3'(idx);
            checkOutput($sformatf("t5 log%0d adr", idx),   K_LADR,
                        logExp(32'(4 * (9 - idx))), 0);
            checkOutput($sformatf("t5 log%0d data", idx),  K_LDATA,
                        logExp(32'(32'h100 + 9 - idx)), 0);
            checkOutput($sformatf("t5 log%0d valid", idx), K_LVALID, logExp(32'd1), 0);
        end
        applyStimulus(1'b1, 32'd40, 32'd1);
        applyStimulus(1'b1, 32'd44, 32'd2);
        pulseReset(1'b1, 32'd48, 32'd3);
        checkOutput("t5 mid rst stores", K_STORES, 32'd0, 0);
        checkOutput("t5 mid rst status", K_STATUS, 32'd0, 0);
        for (int idx = 0; idx < 8; idx++) begin
            applyStimulus(1'b0, 32'd0, 32'd0);
            logRdIdx = 3'(idx);
            checkOutput($sformatf("t5 cleared%0d valid", idx), K_LVALID, 32'd0, 0);
            checkOutput($sformatf("t5 cleared%0d adr", idx),   K_LADR,   32'd0, 0);
        end

        // Reach PASS, reset, then re-arm and pass again.
        resetDut("t6");
        applyStimulus(1'b1, 32'd100, 32'd25);
        checkOutput("t6 first pass", K_STATUS, 32'd1, 1);
        pulseReset(1'b0, 32'd0, 32'd0);
        checkOutput("t6 rearm status", K_STATUS, 32'd0, 0);
        checkOutput("t6 rearm done",   K_DONE,   32'd0, 0);
        checkOutput("t6 rearm stores", K_STORES, 32'd0, 0);
        checkOutput("t6 rearm cycles", K_CYCLES, 32'd0, 0);
        applyStimulus(1'b1, 32'd100, 32'd25);
        checkOutput("t6 second pass", K_STATUS, 32'd1, 1);
        checkOutput("t6 second done", K_DONE,   32'd1, 1);
        checkOutput("t6 second stores", K_STORES, 32'd1, 1);
        applyStimulus(1'b0, 32'd0, 32'd0);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 20 && sbQueue.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        if (sbQueue.size() > 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL scoreboard drain: got %0d pending expected 0", sbQueue.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
